train_sequencer: RTL

Upstream driver for one `neuron_learn` instance. It stores a small set of training samples and seeds the neuron's parameters by holding `valid` low for a fixed number of cycles. It then steps through the samples epoch by epoch, presenting `in`/`expected_out`, measuring the output error and pulsing `learn`. It stops on convergence (a whole epoch within tolerance) or when the epoch limit is reached.

---
 rtl/train_pkg.sv | 33 +++
 rtl/train_sample_mem.sv | 30 +++
 rtl/train_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/train_pkg.sv
// Shared types for the training sequencer: FSM states, sample record and error helper.
// unit_t mirrors the neuron's signed fixed-point word.
package train_pkg;

  localparam int UNIT_W  = 16;
  localparam int TRAIN_N = 16;

  typedef logic signed [UNIT_W-1:0] unit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_FETCH,
    ST_EVAL,
    ST_APPLY,
    ST_EPOCH_END,
    ST_DONE
  } train_state_t;

  typedef struct packed {
    unit_t [TRAIN_N-1:0] in;
    unit_t               expected;
  } train_sample_t;

  // One guard bit keeps the difference exact; the magnitude always fits UNIT_W unsigned bits.
  function automatic logic [UNIT_W-1:0] unit_abs_diff(input unit_t a, input unit_t b);
    logic signed [UNIT_W:0] d;
    d = {a[UNIT_W-1], a} - {b[UNIT_W-1], b};
    if (d < 0) d = -d;
    return d[UNIT_W-1:0];
  endfunction

endpackage

// File: rtl/train_sample_mem.sv
// Sample storage: one write port, one registered read port whose output feeds the neuron directly.
module train_sample_mem
  import train_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  train_sample_t wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output train_sample_t rd_data
);

  train_sample_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds between reads so the neuron sees stable inputs for a whole sample.
  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/train_sequencer.sv
// Drives one neuron_learn instance through stored samples epoch by epoch until convergence or limit.
// Optional macro TRAIN_SEQ_ERR_GATE_EN: learn only on samples that were out of tolerance.
module train_sequencer
  import train_pkg::*;
#(
  parameter int N           = TRAIN_N,
  parameter int DEPTH       = 32,
  parameter int EPOCH_W     = 16,
  parameter int SEED_CYCLES = 8,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  unit_t [N-1:0]      load_in,
  input  unit_t              load_expected,
  input  logic               clear,
  input  logic               start,
  input  logic [EPOCH_W-1:0] max_epochs,
  input  unit_t              tolerance,
  output logic               nl_valid,
  output logic               nl_learn,
  output unit_t [N-1:0]      nl_in,
  output unit_t              nl_expected_out,
  input  unit_t              nl_out,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [CW-1:0]      error_count,
  output logic [CW-1:0]      sample_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [SW-1:0] SEED_LAST = SW'(SEED_CYCLES - 1);

  train_state_t       state, state_nx;
  logic [SW-1:0]      seed_cnt;
  logic [CW-1:0]      idx;
  logic [CW-1:0]      run_err;
  logic [EPOCH_W-1:0] limit;
  logic [UNIT_W-1:0]  tol_u;
  logic [UNIT_W-1:0]  err;
  logic               over_tol;
  logic               last_sample;
  logic               idle_like;
  logic               start_ok;
  logic               wr_en;
  logic               rd_en;
  logic               done_nx;
  train_sample_t      wr_data;
  train_sample_t      rd_data;
`ifdef TRAIN_SEQ_ERR_GATE_EN
  logic               flag;
`endif

  assign idle_like   = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok    = idle_like && start && !clear;
  assign load_ready  = !reset && idle_like && (sample_count < DEPTH_C) && !clear;
  assign wr_en       = load_valid && load_ready;
  assign rd_en       = (state == ST_FETCH);
  assign last_sample = (idx == sample_count - CW'(1));
  assign err         = unit_abs_diff(nl_expected_out, nl_out);
  assign over_tol    = err > tol_u;

  assign busy        = !reset && !idle_like;
  assign nl_valid    = reset || (state != ST_SEED);
`ifdef TRAIN_SEQ_ERR_GATE_EN
  assign nl_learn    = !reset && (state == ST_APPLY) && flag;
`else
  assign nl_learn    = !reset && (state == ST_APPLY);
`endif

  assign wr_data.in       = load_in;
  assign wr_data.expected = load_expected;
  assign nl_in            = rd_data.in;
  assign nl_expected_out  = rd_data.expected;

  train_sample_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (sample_count[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          if (sample_count == '0) begin
            state_nx = ST_DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_SEED;
          end
        end
      end
      ST_SEED:  if (seed_cnt == SEED_LAST) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_EVAL;
      ST_EVAL:  state_nx = ST_APPLY;
      ST_APPLY: state_nx = last_sample ? ST_EPOCH_END : ST_FETCH;
      ST_EPOCH_END: begin
        if ((run_err == '0) || (epoch_count + EPOCH_W'(1) == limit)) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_FETCH;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      converged    <= 1'b0;
      seed_cnt     <= '0;
      idx          <= '0;
      run_err      <= '0;
      epoch_count  <= '0;
      error_count  <= '0;
      sample_count <= '0;
`ifdef TRAIN_SEQ_ERR_GATE_EN
      flag         <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      done  <= done_nx;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (clear) begin
            sample_count <= '0;
          end else begin
            if (wr_en) sample_count <= sample_count + CW'(1);
            if (start) begin
              converged <= 1'b0;
              if (sample_count != '0) begin
                epoch_count <= '0;
                seed_cnt    <= '0;
              end
            end
          end
        end
        ST_SEED: begin
          seed_cnt <= seed_cnt + SW'(1);
          idx      <= '0;
          run_err  <= '0;
        end
        ST_EVAL: begin
`ifdef TRAIN_SEQ_ERR_GATE_EN
          flag <= over_tol;
`endif
          if (over_tol) run_err <= run_err + CW'(1);
        end
        ST_APPLY: begin
          if (!last_sample) idx <= idx + CW'(1);
        end
        // Epoch boundary: publish the epoch's error count and rewind for the next pass.
        ST_EPOCH_END: begin
          epoch_count <= epoch_count + EPOCH_W'(1);
          error_count <= run_err;
          if (run_err == '0) converged <= 1'b1;
          idx     <= '0;
          run_err <= '0;
        end
        default: ;
      endcase
    end
  end

  // Run limits are captured once per run so the inputs may change during training.
  always_ff @(posedge clock) begin
    if (start_ok && (sample_count != '0)) begin
      limit <= (max_epochs == '0) ? EPOCH_W'(1) : max_epochs;
      tol_u <= tolerance;
    end
  end

endmodule
